dma_mem_cpu_master: RTL and testbench
=====================================

DMA_MEM_CPU_MASTER -- requirements
Module: dma_mem_cpu_master

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 196608, meaning number of 16-bit words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 18, meaning word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have command ports:
- cmd_valid  input  1  command request.
- cmd_ready  output  1  accepts a command.
- cmd_op  input  2  operation: 00 FILL_CONST, 01 FILL_INC, 10 READ, 11 illegal.
- cmd_addr  input  18  start word address.
- cmd_len  input  18  word count.
- cmd_data  input  16  fill value or seed.
REQ-006 SHALL have memory-master ports:
- address  output  18  memory word address.
- byteenable  output  2  byte enables.
- chipselect  output  1  memory select.
- write  output  1  write strobe.
- writedata  output  16  write data.
- clken  output  1  memory clock enable.
- reset_req  output  1  memory reset request.
- readdata  input  16  memory read data.
REQ-007 SHALL have read-stream ports:
- rd_valid  output  1  read data available.
- rd_ready  input  1  downstream accepts read data.
- rd_data  output  16  read data word.
REQ-008 SHALL have status ports:
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-009 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-010 SHALL reject an accepted command if any of the following hold, pulsing err the next cycle, performing no memory access, and returning to IDLE:
- cmd_op = 11;
- cmd_len = 0;
- cmd_addr + cmd_len > MEM_DEPTH, computed at 19 bits.
REQ-011 SHALL use states IDLE, WRITE, READ, DRAIN, DONE; IDLE->WRITE for FILL_*, IDLE->READ for READ, WRITE->DONE after the last write, READ->DRAIN after the last issue, DRAIN->DONE when the buffer is empty and nothing is in flight, DONE->IDLE unconditionally.
REQ-012 SHALL, in WRITE, issue one write per cycle with chipselect=1, write=1 and byteenable=11, at address cmd_addr+i for i = 0..len-1.
REQ-013 SHALL drive writedata = cmd_data for FILL_CONST, and writedata = cmd_data+i modulo 2^16 for FILL_INC.
REQ-014 SHALL, in READ, issue a read (chipselect=1, write=0) at cmd_addr+i only when buffer occupancy + in-flight reads < 2.
REQ-015 SHALL capture readdata exactly one cycle after each read issue, which is the fixed memory read latency.
REQ-016 SHALL buffer read data in a 2-entry FIFO; rd_valid = FIFO not empty, rd_data = FIFO head, and the head is popped on rd_valid & rd_ready.
REQ-017 SHALL never drop or duplicate a read word when rd_ready deasserts for any number of cycles; a simultaneous push and pop on a full FIFO is not possible by construction of REQ-014.
REQ-018 SHALL deliver read words in ascending address order.
REQ-019 SHALL drive chipselect=0, write=0 and address=0 whenever no access is issued.
REQ-020 SHALL drive clken=1 and reset_req=0 constantly.
REQ-021 SHALL assert busy in every state except IDLE, and pulse done for exactly one cycle in DONE.
REQ-022 SHALL ignore cmd_valid while busy.
REQ-023 SHALL support the maximum transfer: address wrap is impossible because REQ-010 bounds the range; a command with cmd_addr = MEM_DEPTH-1 and len = 1 SHALL be legal.

Reset
REQ-024 SHALL, on reset, force the following asynchronously:
- state = IDLE;
- FIFO emptied and in-flight count cleared;
- cmd_ready=1 after reset release;
- busy=0, done=0, err=0, rd_valid=0;
- chipselect=0, write=0, address=0, writedata=0, byteenable=00.
REQ-025 SHALL abandon any command in progress when reset asserts mid-operation; no done pulse SHALL follow reset release.

Structure
REQ-026 SHALL take op encodings, MEM_DEPTH and the state enumeration from shared package dma_mem_pkg.
REQ-027 SHALL implement the 2-entry read buffer as sub-module dma_mem_skid_fifo with push, pop, full, empty and count.

Verification
REQ-028 The bench SHALL cover FILL_CONST at addr 0x00100, len 4, data 0xA5A5 -> four consecutive writes to 0x100..0x103 with data A5A5 and byteenable 11, then a done pulse on the cycle after the last write.
REQ-029 The bench SHALL cover FILL_INC at addr 0x2FFFE, len 2, data 0xFFFF -> writes of FFFF at 0x2FFFE and 0000 at 0x2FFFF, then done.
REQ-030 The bench SHALL cover READ at addr 0x00100, len 4 after the REQ-028 fill, with rd_ready low for cycles 3-8 -> exactly four rd_data beats of A5A5 in order, at most 2 reads outstanding, then done.
REQ-031 The bench SHALL cover rejects: op=11, len=0, and addr 0x2FFFF with len 2 -> err pulse, no chipselect, busy returns to 0 within 2 cycles.
REQ-032 The bench SHALL cover reset asserted during the third word of a len-10 READ -> all outputs return to reset values immediately, no done pulse, and the next command executes normally.

Source files
------------

// File: rtl/dma_mem_pkg.sv
// Shared definitions for the DMA memory master: op encodings, memory size and FSM states.
package dma_mem_pkg;

  localparam int unsigned MemDepthDefault = 196608;

  localparam logic [1:0] OpFillConst = 2'b00;
  localparam logic [1:0] OpFillInc   = 2'b01;
  localparam logic [1:0] OpRead      = 2'b10;
  localparam logic [1:0] OpIllegal   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/dma_mem_skid_fifo.sv
// Two-entry read-data buffer with push/pop and occupancy count.
module dma_mem_skid_fifo #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ do_push;
      rd_ptr_q <= rd_ptr_q ^ do_pop;
      count_q  <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dma_mem_cpu_master.sv
// Command-driven memory master: constant/incrementing fills and flow-controlled block reads.
module dma_mem_cpu_master
  import dma_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MemDepthDefault,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [15:0]       cmd_data,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [15:0]       writedata,
  output logic              clken,
  output logic              reset_req,
  input  logic [15:0]       readdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       data_q, data_d;
  logic              inflight_q, inflight_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   end_addr;
  logic              cmd_bad;
  logic              last_idx;
  logic [1:0]        occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              fifo_pop;

  assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign cmd_bad   = (cmd_op == OpIllegal) || (cmd_len == '0) || (end_addr > DepthW);
  assign last_idx  = (idx_q == len_q - ADDR_W'(1));
  // Words already buffered plus the one read that may still be returning.
  assign occupancy = fifo_count + {1'b0, inflight_q};

  assign clken     = 1'b1;
  assign reset_req = 1'b0;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;
  assign rd_valid  = ~fifo_empty;
  assign fifo_pop  = rd_valid & rd_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    inflight_d = 1'b0;
    err_d      = 1'b0;
    cmd_ready  = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    byteenable = 2'b00;
    address    = '0;
    writedata  = '0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            op_d    = cmd_op;
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            data_d  = cmd_data;
            idx_d   = '0;
            state_d = (cmd_op == OpRead) ? StRead : StWrite;
          end
        end
      end
      StWrite: begin
        chipselect = 1'b1;
        write      = 1'b1;
        byteenable = 2'b11;
        address    = addr_q + idx_q;
        writedata  = (op_q == OpFillInc) ? data_q + idx_q[15:0] : data_q;
        idx_d      = idx_q + ADDR_W'(1);
        if (last_idx) begin
          state_d = StDone;
        end
      end
      StRead: begin
        if (occupancy < 2'd2) begin
          chipselect = 1'b1;
          byteenable = 2'b11;
          address    = addr_q + idx_q;
          inflight_d = 1'b1;
          idx_d      = idx_q + ADDR_W'(1);
          if (last_idx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_empty && !inflight_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpFillConst;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Memory latency is fixed at one cycle, so the in-flight read lands now.
  dma_mem_skid_fifo #(
    .Width(16)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (inflight_q),
    .push_data_i(readdata),
    .pop_i      (fifo_pop),
    .head_o     (rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dma_mem_cpu_master.sv
// Directed bench for dma_mem_cpu_master with a one-cycle-latency memory model.
module tb_dma_mem_cpu_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [17:0] cmd_addr;
  logic [17:0] cmd_len;
  logic [15:0] cmd_data;
  logic [17:0] address;
  logic [1:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [15:0] writedata;
  logic        clken;
  logic        reset_req;
  logic [15:0] readdata;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  dma_mem_cpu_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .address   (address),
    .byteenable(byteenable),
    .chipselect(chipselect),
    .write     (write),
    .writedata (writedata),
    .clken     (clken),
    .reset_req (reset_req),
    .readdata  (readdata),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [0:196607];

  int cyc, done_cnt, err_cnt, cs_cnt, rd_iss_cnt, pop_cnt, max_out, done_cyc;
  int first_wr_cyc, last_wr_cyc;
  logic [17:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [1:0]  wb_q[$];
  logic [17:0] ra_q[$];
  logic [15:0] rdq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    readdata = '0;
    forever begin
      @(posedge clk);
      if (chipselect && write) mem[address] <= writedata;
      readdata <= mem[address];
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (chipselect && write) begin
        if (wa_q.size() == 0) first_wr_cyc = cyc;
        wa_q.push_back(address);
        wd_q.push_back(writedata);
        wb_q.push_back(byteenable);
        last_wr_cyc = cyc;
      end
      if (chipselect && !write) begin
        ra_q.push_back(address);
        rd_iss_cnt++;
      end
      if (chipselect) cs_cnt++;
      if (rd_valid && rd_ready) begin
        rdq.push_back(rd_data);
        pop_cnt++;
      end
      if (rd_iss_cnt - pop_cnt > max_out) max_out = rd_iss_cnt - pop_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wb_q.delete();
    ra_q.delete();
    rdq.delete();
    done_cnt   = 0;
    err_cnt    = 0;
    cs_cnt     = 0;
    rd_iss_cnt = 0;
    pop_cnt    = 0;
    max_out    = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [17:0] a, input logic [17:0] l,
                          input logic [15:0] d);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (done_cnt == 0 && i < 200) begin
      step();
      i++;
    end
    check_val({tag, "_done"}, done_cnt, 1);
    check_val({tag, "_idle"}, busy, 0);
  endtask

  task automatic reject_case(input string tag, input logic [1:0] op, input logic [17:0] a,
                             input logic [17:0] l);
    clear_mon();
    send_cmd(op, a, l, 16'h1111);
    check_val({tag, "_err"}, err, 1);
    step();
    check_val({tag, "_err_pulse"}, err, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cs"}, cs_cnt, 0);
    check_val({tag, "_err_cnt"}, err_cnt, 1);
  endtask

  initial begin
    logic [15:0] inc_exp [2];
    logic [15:0] read_exp [2];
    int c;
    inc_exp[0]  = 16'hFFFF;
    inc_exp[1]  = 16'h0000;
    read_exp[0] = 16'hFFFF;
    read_exp[1] = 16'h0000;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    rd_ready  = 1'b1;
    clear_mon();
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_cs", chipselect, 0);
    check_val("rst_write", write, 0);
    check_val("rst_addr", address, 0);
    check_val("rst_wdata", writedata, 0);
    check_val("rst_be", byteenable, 0);
    check_val("clken", clken, 1);
    check_val("reset_req", reset_req, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_cmd_ready", cmd_ready, 1);

    // FILL_CONST 0x100, len 4, A5A5
    clear_mon();
    send_cmd(2'b00, 18'h00100, 18'd4, 16'hA5A5);
    check_val("fc_busy", busy, 1);
    check_val("fc_ready_low", cmd_ready, 0);
    wait_done("fc");
    check_val("fc_nwr", wa_q.size(), 4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("fc_addr%0d", i), wa_q[i], 18'h00100 + 18'(i));
        check_val($sformatf("fc_data%0d", i), wd_q[i], 16'hA5A5);
        check_val($sformatf("fc_be%0d", i), wb_q[i], 2'b11);
      end
    end
    check_val("fc_consec", last_wr_cyc - first_wr_cyc, 3);
    check_val("fc_done_cyc", done_cyc, last_wr_cyc + 1);

    // FILL_INC at top of memory, seed wraps to 0000
    clear_mon();
    send_cmd(2'b01, 18'h2FFFE, 18'd2, 16'hFFFF);
    wait_done("fi");
    check_val("fi_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        check_val($sformatf("fi_addr%0d", i), wa_q[i], 18'h2FFFE + 18'(i));
        check_val($sformatf("fi_data%0d", i), wd_q[i], inc_exp[i]);
      end
    end
    check_val("fi_err", err_cnt, 0);

    // READ 0x100 len 4 with downstream stall
    clear_mon();
    send_cmd(2'b10, 18'h00100, 18'd4, 16'h0000);
    c = 1;
    while (done_cnt == 0 && c < 200) begin
      rd_ready = !(c >= 3 && c <= 8);
      step();
      c++;
    end
    rd_ready = 1'b1;
    check_val("rd_done", done_cnt, 1);
    check_val("rd_beats", rdq.size(), 4);
    check_val("rd_nwr", wa_q.size(), 0);
    check_val("rd_max_out", max_out <= 2, 1);
    if (rdq.size() == 4 && ra_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("rd_data%0d", i), rdq[i], 16'hA5A5);
        check_val($sformatf("rd_addr%0d", i), ra_q[i], 18'h00100 + 18'(i));
      end
    end
    step();
    check_val("rd_idle", busy, 0);

    // READ of the incrementing region checks word order
    clear_mon();
    send_cmd(2'b10, 18'h2FFFE, 18'd2, 16'h0000);
    wait_done("ro");
    check_val("ro_beats", rdq.size(), 2);
    if (rdq.size() == 2) begin
      for (int i = 0; i < 2; i++) check_val($sformatf("ro_data%0d", i), rdq[i], read_exp[i]);
    end

    reject_case("rj_op", 2'b11, 18'h00000, 18'd4);
    reject_case("rj_len0", 2'b00, 18'h00100, 18'd0);
    reject_case("rj_range", 2'b00, 18'h2FFFF, 18'd2);

    // Last word of memory, length 1, is legal
    clear_mon();
    send_cmd(2'b00, 18'h2FFFF, 18'd1, 16'h1234);
    wait_done("edge");
    check_val("edge_err", err_cnt, 0);
    check_val("edge_nwr", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check_val("edge_addr", wa_q[0], 18'h2FFFF);
      check_val("edge_data", wd_q[0], 16'h1234);
    end

    // Reset during the third word of a len-10 READ
    clear_mon();
    send_cmd(2'b10, 18'h00100, 18'd10, 16'h0000);
    c = 0;
    while (rd_iss_cnt < 3 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_val("mr_third_issue", rd_iss_cnt, 3);
    #2 reset = 1'b1;
    #1;
    check_val("mr_busy", busy, 0);
    check_val("mr_cs", chipselect, 0);
    check_val("mr_addr", address, 0);
    check_val("mr_rd_valid", rd_valid, 0);
    check_val("mr_be", byteenable, 0);
    check_val("mr_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    repeat (10) step();
    check_val("mr_no_done", done_cnt, 0);
    check_val("mr_no_cs", cs_cnt, 0);
    check_val("mr_ready", cmd_ready, 1);

    clear_mon();
    send_cmd(2'b00, 18'h00200, 18'd2, 16'h5A5A);
    wait_done("post_fill");
    check_val("post_nwr", wa_q.size(), 2);
    clear_mon();
    send_cmd(2'b10, 18'h00200, 18'd2, 16'h0000);
    wait_done("post_read");
    check_val("post_beats", rdq.size(), 2);
    if (rdq.size() == 2) begin
      check_val("post_data0", rdq[0], 16'h5A5A);
      check_val("post_data1", rdq[1], 16'h5A5A);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
